manual_clock_stepper: RTL and testbench

//   Upstream stage of the multicycle processor on the DE2 board: turns the raw, bouncing

---
 rtl/manual_clock_stepper.sv | 178 +++++++++++++++++
 tb/tb_manual_clock_stepper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/manual_clock_stepper.sv
// Debounced push-button to single-step processor clock: one fixed-width StepClock period per press.
// Optional macro AUTO_STEP_EN adds the AutoMode port and a free-running step divider.
module manual_clock_stepper #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 8,
    parameter int AUTO_DIV        = 25000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        KEYn,
`ifdef AUTO_STEP_EN
    input  logic        AutoMode,
`endif
    output logic        StepClock,
    output logic        StepPulse,
    output logic        Busy,
    output logic [15:0] StepCount
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (PULSE_CYCLES > 2) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 || AUTO_DIV < 1) begin : g_bad_cfg
        $error("manual_clock_stepper: cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HIGH      = 2'd1,
        ST_LOW_GUARD = 2'd2
    } state_e;

    logic          sync1_q, sync1_d;
    logic          ks_q, ks_d;
    logic          stable_q, stable_d;
    logic          stable_prev_q, stable_prev_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          step_clk_q, step_clk_d;
    logic          step_pulse_q, step_pulse_d;
    logic          busy_q, busy_d;
    logic [15:0]   step_count_q, step_count_d;
    logic          press_s;
    logic          step_req_s;
`ifdef AUTO_STEP_EN
    localparam int AW = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
    localparam logic [AW-1:0] DIV_LAST = AW'(AUTO_DIV - 1);
    logic [AW-1:0] div_q, div_d;
    logic          auto_tick_s;
`endif

    // Next-state logic: synchroniser, debouncer, step request and step FSM
    always_comb begin
        sync1_d       = KEYn;
        ks_d          = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        dcnt_d        = '0;
        if (ks_q != stable_q) begin
            if (dcnt_q == DCNT_LAST) begin
                stable_d = ks_q;
                dcnt_d   = '0;
            end else begin
                dcnt_d = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
            end
        end else begin
            dcnt_d = '0;
        end

        // Press is the registered falling edge of the debounced level; release is ignored
        press_s = stable_prev_q & ~stable_q;

`ifdef AUTO_STEP_EN
        auto_tick_s = 1'b0;
        if (AutoMode) begin
            if (div_q == DIV_LAST) begin
                div_d       = '0;
                auto_tick_s = 1'b1;
            end else begin
                div_d = div_q + {{(AW-1){1'b0}}, 1'b1};
            end
        end else begin
            div_d = '0;
        end
        step_req_s = AutoMode ? auto_tick_s : press_s;
`else
        step_req_s = press_s;
`endif

        state_d      = state_q;
        pcnt_d       = pcnt_q;
        step_clk_d   = step_clk_q;
        step_pulse_d = 1'b0;
        step_count_d = step_count_q;
        case (state_q)
            ST_IDLE: begin
                pcnt_d = '0;
                if (step_req_s) begin
                    state_d      = ST_HIGH;
                    step_clk_d   = 1'b1;
                    step_pulse_d = 1'b1;
                    step_count_d = step_count_q + 16'd1;
                end else begin
                    step_clk_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (pcnt_q == PCNT_LAST) begin
                    state_d    = ST_LOW_GUARD;
                    step_clk_d = 1'b0;
                    pcnt_d     = '0;
                end else begin
                    step_clk_d = 1'b1;
                    pcnt_d     = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            ST_LOW_GUARD: begin
                step_clk_d = 1'b0;
                if (pcnt_q == PCNT_LAST) begin
                    state_d = ST_IDLE;
                    pcnt_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d    = ST_IDLE;
                step_clk_d = 1'b0;
                pcnt_d     = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q       <= 1'b1;
            ks_q          <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            dcnt_q        <= '0;
            state_q       <= ST_IDLE;
            pcnt_q        <= '0;
            step_clk_q    <= 1'b0;
            step_pulse_q  <= 1'b0;
            busy_q        <= 1'b0;
            step_count_q  <= 16'd0;
`ifdef AUTO_STEP_EN
            div_q         <= '0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            ks_q          <= ks_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            dcnt_q        <= dcnt_d;
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            step_clk_q    <= step_clk_d;
            step_pulse_q  <= step_pulse_d;
            busy_q        <= busy_d;
            step_count_q  <= step_count_d;
`ifdef AUTO_STEP_EN
            div_q         <= div_d;
`endif
        end
    end

    assign StepClock = step_clk_q;
    assign StepPulse = step_pulse_q;
    assign Busy      = busy_q;
    assign StepCount = step_count_q;

endmodule

// File: tb/tb_manual_clock_stepper.sv
// Bench for manual_clock_stepper (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, AUTO_DIV=20).
// Reference model works from raw key sample history and step start times, not from RTL state.
module tb_manual_clock_stepper;
    localparam int D = 4;
    localparam int P = 2;
    localparam int A = 20;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        KEYn  = 1'b1;
`ifdef AUTO_STEP_EN
    logic        AutoMode = 1'b0;
`endif
    logic        StepClock, StepPulse, Busy;
    logic [15:0] StepCount;

    manual_clock_stepper #(
        .DEBOUNCE_CYCLES(D),
        .PULSE_CYCLES   (P),
        .AUTO_DIV       (A)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .KEYn     (KEYn),
`ifdef AUTO_STEP_EN
        .AutoMode (AutoMode),
`endif
        .StepClock(StepClock),
        .StepPulse(StepPulse),
        .Busy     (Busy),
        .StepCount(StepCount)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    // Reference model: key samples (index 0 = newest), debounced level, step start edge
    int  cyc = 0;
    bit  hq[$];
    bit  m_cur = 1'b1;
    bit  m_prv = 1'b1;
    int  last_start = -1000;
    int  m_count = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit key);
        bit all_diff;
        bit pressed;
        bit idle;
        cyc++;
        if (rst) begin
            hq.delete();
            for (int i = 0; i <= D; i++) hq.push_front(1'b1);
            m_cur = 1'b1;
            m_prv = 1'b1;
            last_start = -1000;
            m_count = 0;
        end else begin
            // Level flips once the last D synchronised samples all disagree with it
            all_diff = 1'b1;
            for (int i = 1; i <= D; i++) if (hq[i] == m_cur) all_diff = 1'b0;
            pressed = (m_cur == 1'b0) && (m_prv == 1'b1);
            idle = (cyc - 1) >= last_start + 2 * P;
            if (pressed && idle) begin
                last_start = cyc;
                m_count = (m_count + 1) % 65536;
            end
            m_prv = m_cur;
            if (all_diff) m_cur = ~m_cur;
            hq.push_front(key);
            void'(hq.pop_back());
        end
    endtask

    task automatic tick();
        int d;
        @(posedge Clock);
        model_edge(Reset, KEYn);
        #1;
        d = cyc - last_start;
        check("step_clock", {15'd0, StepClock}, {15'd0, (d >= 0 && d < P) ? 1'b1 : 1'b0});
        check("step_pulse", {15'd0, StepPulse}, {15'd0, (d == 0) ? 1'b1 : 1'b0});
        check("busy",       {15'd0, Busy},      {15'd0, (d >= 0 && d < 2 * P) ? 1'b1 : 1'b0});
        check("step_count", StepCount, 16'(m_count));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bit seen;
        int seg_len;

        // Reset held three cycles with key released
        Reset = 1'b1;
        KEYn  = 1'b1;
        ticks(3);
        check("t1_count", StepCount, 16'd0);
        check("t1_clk", {15'd0, StepClock}, 16'd0);
        Reset = 1'b0;
        while (cyc < 10) tick();

        // Clean press at cycle 10: fixed latency and pulse shape
        KEYn = 1'b0;
        for (int c = 11; c <= 21; c++) begin
            tick();
            check("t2_clk",   {15'd0, StepClock}, {15'd0, (c == 17 || c == 18) ? 1'b1 : 1'b0});
            check("t2_pulse", {15'd0, StepPulse}, {15'd0, (c == 17) ? 1'b1 : 1'b0});
            check("t2_busy",  {15'd0, Busy},      {15'd0, (c >= 17 && c <= 20) ? 1'b1 : 1'b0});
        end
        check("t2_count", StepCount, 16'd1);
        ticks(6);
        KEYn = 1'b1;
        ticks(12);

        // Short bounce never accepted
        KEYn = 1'b0;
        ticks(3);
        KEYn = 1'b1;
        ticks(12);
        check("t3_count", StepCount, 16'd1);

        // Held key with a brief release during the step yields one step, then one clean press
        KEYn = 1'b0;
        ticks(9);
        KEYn = 1'b1;
        ticks(3);
        KEYn = 1'b0;
        ticks(10);
        KEYn = 1'b1;
        ticks(12);
        KEYn = 1'b0;
        ticks(12);
        KEYn = 1'b1;
        ticks(12);
        check("t4_count", StepCount, 16'd3);

        // Reset landing on the first HIGH cycle
        KEYn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (StepPulse === 1'b1) seen = 1'b1;
        end
        check("t5_pulse_seen", {15'd0, seen}, 16'd1);
        Reset = 1'b1;
        KEYn  = 1'b1;
        tick();
        check("t5_clk",   {15'd0, StepClock}, 16'd0);
        check("t5_busy",  {15'd0, Busy},      16'd0);
        check("t5_count", StepCount, 16'd0);
        Reset = 1'b0;
        ticks(8);

        // Counter wrap from 0xFFFF
        force dut.step_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        release dut.step_count_q;
        ticks(2);
        check("t6_before", StepCount, 16'hFFFF);
        KEYn = 1'b0;
        ticks(12);
        KEYn = 1'b1;
        ticks(12);
        check("t6_wrap", StepCount, 16'h0000);

        // Randomised key activity with occasional resets
        for (int s = 0; s < 60; s++) begin
            KEYn = 1'($urandom_range(0, 1));
            seg_len = $urandom_range(1, 12);
            if ($urandom_range(0, 15) == 0) begin
                Reset = 1'b1;
                tick();
                Reset = 1'b0;
            end
            ticks(seg_len);
        end
        KEYn = 1'b1;
        ticks(12);

`ifdef AUTO_STEP_EN
        // Free-running steps: one pulse every A cycles, button ignored
        begin
            int pulses;
            int last_p;
            pulses = 0;
            last_p = -1;
            AutoMode = 1'b1;
            for (int i = 0; i < 5 * A; i++) begin
                KEYn = 1'($urandom_range(0, 1));
                @(posedge Clock);
                #1;
                if (StepPulse === 1'b1) begin
                    if (last_p >= 0) check("t7_gap", 16'(i - last_p), 16'(A));
                    last_p = i;
                    pulses++;
                end
            end
            check("t7_pulses", 16'(pulses), 16'd5);
            AutoMode = 1'b0;
            KEYn = 1'b1;
            pulses = 0;
            for (int i = 0; i < 3 * A; i++) begin
                @(posedge Clock);
                #1;
                if (StepPulse === 1'b1 && i >= 2 * P) pulses++;
            end
            check("t7_stopped", 16'(pulses), 16'd0);
            Reset = 1'b1;
            tick();
            Reset = 1'b0;
            ticks(4);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
